// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single synchronous memory port: data side has fixed priority,
// instruction side gets an optional starvation guard when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_port_arbiter #(
    parameter int          AW         = 10,
    parameter int          DW         = 32,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic          CLK,
    input  logic          RST_X,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic i_win;
    logic d_win;
    logic i_force;
    logic rsp_i_reg;
    logic rsp_d_reg;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_reg;
    logic [3:0] starve_next;

    // I overrides D once it has been refused STARVE_LIM cycles in a row.
    assign i_force = i_req && (starve_reg == STARVE_LIM);

    always_comb begin
        starve_next = 4'd0;
        if (i_req && !i_gnt) begin
            starve_next = (starve_reg >= STARVE_LIM) ? STARVE_LIM : starve_reg + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            starve_reg <= 4'd0;
        end else begin
            starve_reg <= starve_next;
        end
    end
`else
    logic [3:0] unused_starve_max;

    assign unused_starve_max = 4'(STARVE_MAX);
    assign i_force           = 1'b0;
`endif

    assign i_win = i_req && (!d_req || i_force);
    assign d_win = d_req && !i_win;

    // Grants are masked while reset is held so the memory sees no access.
    assign i_gnt = i_win && RST_X;
    assign d_gnt = d_win && RST_X;

    assign mem_en    = i_gnt || d_gnt;
    assign mem_we    = d_gnt && d_we;
    assign mem_addr  = i_gnt ? i_addr : d_addr;
    assign mem_wdata = d_wdata;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            rsp_i_reg <= 1'b0;
            rsp_d_reg <= 1'b0;
        end else begin
            rsp_i_reg <= i_gnt;
            rsp_d_reg <= d_gnt && !d_we;
        end
    end

    assign i_rvalid = rsp_i_reg;
    assign d_rvalid = rsp_d_reg;
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reset checks, a directed vector table, starvation and
// mid-access reset sequences, then random traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SMAX = 3;

    logic          CLK;
    logic          RST_X;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .CLK(CLK), .RST_X(RST_X),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory array behind the port: registered read, write on enable.
    logic [DW-1:0] tb_mem [0:(1<<AW)-1];
    always @(posedge CLK) begin
        if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    // Transaction-level reference: memory contents, outstanding responses, refusal streak.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            m_refused;
    bit            m_rsp_i;
    bit            m_rsp_d;
    logic [DW-1:0] m_rdata;

    function automatic void model_reset();
        m_refused = 0;
        m_rsp_i   = 1'b0;
        m_rsp_d   = 1'b0;
    endfunction

    function automatic void model_grant(input bit ir, input bit dr, output bit ig, output bit dg);
        bit starved;
`ifdef MEM_ARB_STARVE_GUARD_EN
        starved = ir && (m_refused >= SMAX);
`else
        starved = 1'b0;
`endif
        ig = ir && (!dr || starved);
        dg = dr && !ig;
    endfunction

    function automatic void model_commit(input bit ir, input bit dwe, input logic [AW-1:0] ia,
                                         input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                                         input bit ig, input bit dg);
        m_rsp_i = ig;
        m_rsp_d = dg && !dwe;
        if (ig) m_rdata = ref_mem[ia];
        else if (dg) begin
            if (dwe) ref_mem[da] = dwd;
            else     m_rdata = ref_mem[da];
        end
        if (ir && !ig) m_refused = (m_refused + 1 > SMAX) ? SMAX : m_refused + 1;
        else           m_refused = 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit ir, input bit dr, input bit dwe, input logic [AW-1:0] ia,
                         input logic [AW-1:0] da, input logic [DW-1:0] dwd);
        i_req = ir; d_req = dr; d_we = dwe; i_addr = ia; d_addr = da; d_wdata = dwd;
    endtask

    // One model-checked cycle; entered and left just after a falling edge.
    task automatic do_cycle(input bit ir, input bit dr, input bit dwe, input logic [AW-1:0] ia,
                            input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                            output bit ig, output bit dg);
        drive(ir, dr, dwe, ia, da, dwd);
        #2;
        model_grant(ir, dr, ig, dg);
        chk("i_gnt", 32'(i_gnt), 32'(ig));
        chk("d_gnt", 32'(d_gnt), 32'(dg));
        chk("mem_en", 32'(mem_en), 32'(ig | dg));
        chk("mem_we", 32'(mem_we), 32'(dg & dwe));
        if (ig)      chk("mem_addr_i", 32'(mem_addr), 32'(ia));
        else if (dg) chk("mem_addr_d", 32'(mem_addr), 32'(da));
        if (dg && dwe) chk("mem_wdata", mem_wdata, dwd);
        chk("i_rvalid", 32'(i_rvalid), 32'(m_rsp_i));
        chk("d_rvalid", 32'(d_rvalid), 32'(m_rsp_d));
        if (m_rsp_i) chk("i_rdata", i_rdata, m_rdata);
        if (m_rsp_d) chk("d_rdata", d_rdata, m_rdata);
        model_commit(ir, dwe, ia, da, dwd, ig, dg);
        @(negedge CLK);
    endtask

    typedef struct {
        bit            ir, dr, dwe;
        logic [AW-1:0] ia, da;
        logic [DW-1:0] dwd;
        bit            e_ig, e_dg, e_we;
        logic [AW-1:0] e_addr;
        bit            e_irv, e_drv;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t vecs [7];

    bit            ig, dg;
    bit            r_ir, r_dr, r_dwe;
    logic [AW-1:0] r_ia, r_da;
    logic [DW-1:0] r_dwd;

    initial begin
        for (int k = 0; k < (1 << AW); k++) begin
            tb_mem[k]  = 32'hA5A5_0000 ^ 32'(k * 7);
            ref_mem[k] = 32'hA5A5_0000 ^ 32'(k * 7);
        end
        tb_mem[5]  = 32'h0000_0013;
        ref_mem[5] = 32'h0000_0013;
        mem_rdata  = '0;

        //           ir dr we ia  da  dwd           ig dg we addr irv drv rdata
        vecs[0] = '{1, 0, 0, 5,  0,  32'h0,        1, 0, 0, 5,   0,  0,  32'h0};
        vecs[1] = '{0, 0, 0, 0,  0,  32'h0,        0, 0, 0, 0,   1,  0,  32'h13};
        vecs[2] = '{1, 1, 1, 8,  8,  32'hCAFE,     0, 1, 1, 8,   0,  0,  32'h0};
        vecs[3] = '{1, 0, 0, 8,  0,  32'h0,        1, 0, 0, 8,   0,  0,  32'h0};
        vecs[4] = '{0, 0, 0, 0,  0,  32'h0,        0, 0, 0, 0,   1,  0,  32'hCAFE};
        vecs[5] = '{0, 1, 0, 0,  8,  32'h0,        0, 1, 0, 8,   0,  0,  32'h0};
        vecs[6] = '{0, 0, 0, 0,  0,  32'h0,        0, 0, 0, 0,   0,  1,  32'hCAFE};

        // Reset held with both requests up: nothing may reach the memory.
        RST_X = 1'b0;
        model_reset();
        drive(1, 1, 0, 5, 3, 32'h0);
        #2;
        chk("rst_i_gnt", 32'(i_gnt), 0);
        chk("rst_d_gnt", 32'(d_gnt), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        @(posedge CLK); #2;
        chk("rst_i_rvalid", 32'(i_rvalid), 0);
        chk("rst_d_rvalid", 32'(d_rvalid), 0);
        @(negedge CLK);
        RST_X = 1'b1;
        do_cycle(1, 1, 0, 5, 3, 32'h0, ig, dg);
        $display("reset release: i_gnt=%0b d_gnt=%0b", ig, dg);
        chk("first_d_gnt", 32'(dg), 1);
        do_cycle(0, 0, 0, 0, 0, 32'h0, ig, dg);

        // Directed vectors: I-only read, contention with a D write, D read back.
        for (int v = 0; v < 7; v++) begin
            drive(vecs[v].ir, vecs[v].dr, vecs[v].dwe, vecs[v].ia, vecs[v].da, vecs[v].dwd);
            #2;
            $display("vec %0d: i_gnt=%0b d_gnt=%0b mem_we=%0b addr=%0d i_rv=%0b d_rv=%0b",
                     v, i_gnt, d_gnt, mem_we, mem_addr, i_rvalid, d_rvalid);
            chk("vec_i_gnt", 32'(i_gnt), 32'(vecs[v].e_ig));
            chk("vec_d_gnt", 32'(d_gnt), 32'(vecs[v].e_dg));
            chk("vec_mem_en", 32'(mem_en), 32'(vecs[v].e_ig | vecs[v].e_dg));
            chk("vec_mem_we", 32'(mem_we), 32'(vecs[v].e_we));
            if (vecs[v].e_ig | vecs[v].e_dg) chk("vec_mem_addr", 32'(mem_addr), 32'(vecs[v].e_addr));
            if (vecs[v].e_we) chk("vec_mem_wdata", mem_wdata, vecs[v].dwd);
            chk("vec_i_rvalid", 32'(i_rvalid), 32'(vecs[v].e_irv));
            chk("vec_d_rvalid", 32'(d_rvalid), 32'(vecs[v].e_drv));
            if (vecs[v].e_irv) chk("vec_i_rdata", i_rdata, vecs[v].e_rdata);
            if (vecs[v].e_drv) chk("vec_d_rdata", d_rdata, vecs[v].e_rdata);
            model_grant(vecs[v].ir, vecs[v].dr, ig, dg);
            model_commit(vecs[v].ir, vecs[v].dwe, vecs[v].ia, vecs[v].da, vecs[v].dwd, ig, dg);
            @(negedge CLK);
        end

        // Continuous contention: I wins every fourth cycle only with the guard.
        do_cycle(0, 0, 0, 0, 0, 32'h0, ig, dg);
        for (int c = 0; c < 20; c++) begin
            bit exp_i;
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_i = ((c % (SMAX + 1)) == SMAX);
`else
            exp_i = 1'b0;
`endif
            do_cycle(1, 1, 0, 5, 10'(c), 32'h0, ig, dg);
            $display("starve cycle %0d: i_gnt expected %0b", c, exp_i);
            chk("starve_i_gnt", 32'(ig), 32'(exp_i));
        end
        do_cycle(0, 0, 0, 0, 0, 32'h0, ig, dg);

        // Reset pulled after a D read is granted but before the edge.
        drive(0, 1, 0, 0, 5, 32'h0);
        #2;
        chk("mid_d_gnt", 32'(d_gnt), 1);
        #1 RST_X = 1'b0;
        #1 chk("mid_gnt_forced", 32'(d_gnt), 0);
        @(posedge CLK); #1;
        chk("mid_d_rvalid_rst", 32'(d_rvalid), 0);
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 32'h0);
        #2 RST_X = 1'b1;
        @(posedge CLK); #1;
        chk("mid_d_rvalid_rel", 32'(d_rvalid), 0);
        model_reset();
        @(negedge CLK);

        // Reset arriving while a read response is on the bus clears it at once.
        drive(0, 1, 0, 0, 5, 32'h0);
        @(posedge CLK); #1;
        chk("rsp_d_rvalid", 32'(d_rvalid), 1);
        chk("rsp_d_rdata", d_rdata, ref_mem[5]);
        #1 RST_X = 1'b0;
        #1 chk("async_d_rvalid", 32'(d_rvalid), 0);
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 32'h0);
        RST_X = 1'b1;
        model_reset();
        $display("mid-access reset sequences done");
        do_cycle(0, 0, 0, 0, 0, 32'h0, ig, dg);

        // Random traffic; a refused request is held with its payload until granted.
        r_ir = 0; r_dr = 0; r_dwe = 0; r_ia = '0; r_da = '0; r_dwd = '0;
        for (int n = 0; n < 300; n++) begin
            if (!r_ir) begin
                r_ir = ($urandom_range(0, 99) < 60);
                r_ia = 10'($urandom_range(0, 15));
            end
            if (!r_dr) begin
                r_dr  = ($urandom_range(0, 99) < 70);
                r_dwe = $urandom_range(0, 1) == 1;
                r_da  = 10'($urandom_range(0, 15));
                r_dwd = $urandom;
            end
            do_cycle(r_ir, r_dr, r_dwe, r_ia, r_da, r_dwd, ig, dg);
            $display("rand %0d: i_req=%0b d_req=%0b d_we=%0b -> i_gnt=%0b d_gnt=%0b",
                     n, r_ir, r_dr, r_dwe, ig, dg);
            if (ig) r_ir = 1'b0;
            if (dg) r_dr = 1'b0;
        end
        do_cycle(0, 0, 0, 0, 0, 32'h0, ig, dg);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
